// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit. It does one radix-2 step per enabled clock:
// shift-add for multiply, restoring subtraction for divide.
module muldiv_unit #(
    parameter int NB_REG = 32,
    parameter int NB_OP  = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_dunit_clk_en,
    input  logic              i_start,
    input  logic [NB_OP-1:0]  i_operation,
    input  logic [NB_REG-1:0] i_rs_data,
    input  logic [NB_REG-1:0] i_rt_data,
    output logic [NB_REG-1:0] o_hi,
    output logic [NB_REG-1:0] o_lo,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [NB_OP-1:0] F_MTHI  = NB_OP'('h11);
    localparam logic [NB_OP-1:0] F_MTLO  = NB_OP'('h13);
    localparam logic [NB_OP-1:0] F_MULT  = NB_OP'('h18);
    localparam logic [NB_OP-1:0] F_MULTU = NB_OP'('h19);
    localparam logic [NB_OP-1:0] F_DIV   = NB_OP'('h1A);
    localparam logic [NB_OP-1:0] F_DIVU  = NB_OP'('h1B);
    localparam logic [5:0]       LAST_ITER = 6'(NB_REG - 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t state, state_next;
    logic [5:0] iter_cnt;

    logic is_mul_op, is_div_op, is_signed_op, start_md;

    logic              op_is_div, neg_res, neg_rem, div_zero;
    logic [NB_REG-1:0] rs_raw, operand_b, acc_hi, acc_lo;

    logic [NB_REG:0]     mul_sum, div_shift;
    logic [2*NB_REG-1:0] product;
    logic [NB_REG-1:0]   fin_hi, fin_lo;

    function automatic logic [NB_REG-1:0] magnitude(input logic signed [NB_REG-1:0] v,
                                                    input logic use_sign);
        if (use_sign && v[NB_REG-1]) return $unsigned(-v);
        return $unsigned(v);
    endfunction

    function automatic logic [NB_REG-1:0] cond_neg(input logic [NB_REG-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*NB_REG-1:0] cond_neg_wide(input logic [2*NB_REG-1:0] v,
                                                          input logic neg);
        return neg ? -v : v;
    endfunction

    assign is_mul_op    = (i_operation == F_MULT) || (i_operation == F_MULTU);
    assign is_div_op    = (i_operation == F_DIV)  || (i_operation == F_DIVU);
    assign is_signed_op = (i_operation == F_MULT) || (i_operation == F_DIV);
    assign start_md     = (state == IDLE) && i_start && (is_mul_op || is_div_op);
    assign o_busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_md) state_next = CALC;
            CALC:    if (iter_cnt == LAST_ITER) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            iter_cnt <= '0;
            o_done   <= 1'b0;
        end else if (i_dunit_clk_en) begin
            state  <= state_next;
            o_done <= (state == FINISH);
            if (start_md)
                iter_cnt <= '0;
            else if (state == CALC)
                iter_cnt <= iter_cnt + 6'd1;
        end
    end

    // Iteration step: the multiply keeps {carry,partial} in acc_hi and shifts the
    // multiplier out of acc_lo; the divide shifts the dividend from acc_lo into acc_hi.
    assign mul_sum   = {1'b0, acc_hi} + {1'b0, operand_b};
    assign div_shift = {acc_hi, acc_lo[NB_REG-1]};

    always_ff @(posedge i_clk) begin
        if (i_dunit_clk_en) begin
            if (start_md) begin
                op_is_div <= is_div_op;
                neg_res   <= is_signed_op && (i_rs_data[NB_REG-1] ^ i_rt_data[NB_REG-1]);
                neg_rem   <= is_signed_op && i_rs_data[NB_REG-1];
                div_zero  <= is_div_op && (i_rt_data == '0);
                rs_raw    <= i_rs_data;
                acc_hi    <= '0;
                if (is_div_op) begin
                    operand_b <= magnitude($signed(i_rt_data), is_signed_op);
                    acc_lo    <= magnitude($signed(i_rs_data), is_signed_op);
                end else begin
                    operand_b <= magnitude($signed(i_rs_data), is_signed_op);
                    acc_lo    <= magnitude($signed(i_rt_data), is_signed_op);
                end
            end else if (state == CALC) begin
                if (op_is_div) begin
                    if (div_shift >= {1'b0, operand_b}) begin
                        acc_hi <= NB_REG'(div_shift - {1'b0, operand_b});
                        acc_lo <= {acc_lo[NB_REG-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[NB_REG-1:0];
                        acc_lo <= {acc_lo[NB_REG-2:0], 1'b0};
                    end
                end else if (acc_lo[0]) begin
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[NB_REG-1:1]};
                end else begin
                    {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[NB_REG-1:1]};
                end
            end
        end
    end

    always_comb begin
        product = cond_neg_wide({acc_hi, acc_lo}, neg_res);
        fin_hi  = product[2*NB_REG-1:NB_REG];
        fin_lo  = product[NB_REG-1:0];
        if (op_is_div) begin
            if (div_zero) begin
                fin_lo = '1;
                fin_hi = rs_raw;
            end else begin
                fin_lo = cond_neg(acc_lo, neg_res);
                fin_hi = cond_neg(acc_hi, neg_rem);
            end
        end
    end

    // HI/LO are architecturally visible: only the FINISH edge or MTHI/MTLO may write them.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_hi <= '0;
            o_lo <= '0;
        end else if (i_dunit_clk_en) begin
            if (state == FINISH) begin
                o_hi <= fin_hi;
                o_lo <= fin_lo;
            end else if (state == IDLE && i_start && i_operation == F_MTHI) begin
                o_hi <= i_rs_data;
            end else if (state == IDLE && i_start && i_operation == F_MTLO) begin
                o_lo <= i_rs_data;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: latency, signed/unsigned results, corner cases,
// clock-enable freeze, reset abort and MTHI/MTLO.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  op = 6'h00;
    logic [31:0] rs = 32'h0;
    logic [31:0] rt = 32'h0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.NB_REG(32), .NB_OP(6)) dut (
        .i_clk(clk), .i_reset(rst), .i_dunit_clk_en(en), .i_start(start),
        .i_operation(op), .i_rs_data(rs), .i_rt_data(rt),
        .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_done(done)
    );

    // Starts at the current negedge; returns at the negedge after the done pulse.
    task automatic run_muldiv(input string name, input logic [5:0] fn,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi0, lo0;
        int k, busy_cnt;
        hi0 = hi; lo0 = lo;
        op = fn; rs = a; rt = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; k = 0; busy_cnt = 0;
        while (done !== 1'b1 && k < 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (k == 32) begin
                n_tests++;
                if (hi !== hi0 || lo !== lo0) begin
                    n_fail++;
                    $display("FAIL %s_early_write: hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, hi0, lo0);
                end
            end
            @(negedge clk); k++;
        end
        n_tests++;
        if (k !== 33) begin n_fail++; $display("FAIL %s_latency: %0d edges, required 33", name, k); end
        n_tests++;
        if (busy_cnt !== 33) begin n_fail++; $display("FAIL %s_busy_cycles: %0d, required 33", name, busy_cnt); end
        n_tests++;
        if (hi !== exp_hi) begin n_fail++; $display("FAIL %s_hi: %h, required %h", name, hi, exp_hi); end
        n_tests++;
        if (lo !== exp_lo) begin n_fail++; $display("FAIL %s_lo: %h, required %h", name, lo, exp_lo); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_end: %b, required 0", name, busy); end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse: %b, required 0", name, done); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++; $display("FAIL reset_hilo: hi=%h lo=%h, required 0/0", hi, lo);
        end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b, required 0/0", busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_mthi_mtlo();
        op = 6'h11; rs = 32'hA5A5_0001; start = 1'b1;
        @(negedge clk);
        op = 6'h13; rs = 32'h5A5A_0002;
        n_tests++;
        if (hi !== 32'hA5A5_0001 || lo !== 32'h0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mthi: hi=%h lo=%h busy=%b, required a5a50001/0/0", hi, lo, busy);
        end
        @(negedge clk);
        op = 6'h20; rs = 32'hDEAD_BEEF;
        n_tests++;
        if (lo !== 32'h5A5A_0002 || hi !== 32'hA5A5_0001 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, required a5a50001/5a5a0002/0/0", hi, lo, busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (hi !== 32'hA5A5_0001 || lo !== 32'h5A5A_0002 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bad_funct: hi=%h lo=%h busy=%b, required a5a50001/5a5a0002/0", hi, lo, busy);
        end
    endtask

    task automatic test_multu();
        run_muldiv("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    endtask

    task automatic test_signed();
        run_muldiv("mult_neg", 6'h18, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_muldiv("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_muldiv("mult_both_neg", 6'h18, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'h0, 32'd14);
    endtask

    task automatic test_div_edge();
        run_muldiv("divu_zero", 6'h1B, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
        run_muldiv("div_zero_neg", 6'h1A, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_muldiv("div_overflow", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_muldiv("divu_big", 6'h1B, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);
    endtask

    task automatic test_clk_en();
        int k, busy_cnt;
        op = 6'h1B; rs = 32'd100; rt = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; k = 0; busy_cnt = 0;
        while (done !== 1'b1 && k < 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (k == 3) begin op = 6'h19; rs = 32'd5; rt = 32'd5; start = 1'b1; end
            else start = 1'b0;
            en = (k >= 10 && k < 15) ? 1'b0 : 1'b1;
            @(negedge clk); k++;
        end
        en = 1'b1; start = 1'b0;
        n_tests++;
        if (k !== 38) begin n_fail++; $display("FAIL clken_latency: %0d edges, required 38", k); end
        n_tests++;
        if (busy_cnt !== 38) begin n_fail++; $display("FAIL clken_busy_cycles: %0d, required 38", busy_cnt); end
        n_tests++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            n_fail++; $display("FAIL clken_result: hi=%h lo=%h, required 2/e", hi, lo);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL clken_idle: done=%b busy=%b, required 0/0", done, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int k, done_cnt;
        op = 6'h19; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0; k = 0;
        while (k < 9) begin @(negedge clk); k++; end
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_ctrl: busy=%b done=%b, required 0/0", busy, done);
        end
        n_tests++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_hilo: hi=%h lo=%h, required 0/0", hi, lo);
        end
        rst = 1'b0; en = 1'b1; done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        n_tests++;
        if (done_cnt !== 0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_resume: activity=%0d hi=%h lo=%h, required 0/0/0", done_cnt, hi, lo);
        end
        op = 6'h13; rs = 32'hCAFE_BABE; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (lo !== 32'hCAFE_BABE || hi !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mtlo_after_rst: hi=%h lo=%h busy=%b done=%b, required 0/cafebabe/0/0", hi, lo, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        run_muldiv("b2b_mul", 6'h19, 32'd7, 32'd6, 32'h0, 32'd42);
        run_muldiv("b2b_div", 6'h1B, 32'd42, 32'd5, 32'd2, 32'd8);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mthi_mtlo();
        test_multu();
        test_signed();
        test_div_edge();
        test_clk_en();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter NB_REG, default 32: data width of rs/rt operands, HI and LO.
REQ-002 Parameter NB_OP, default 6: width of the function-code input.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_dunit_clk_en  input  1  debug-unit clock enable; low freezes all state.
REQ-006 i_start  input  1  EX-stage request; the funct on i_operation is valid this cycle.
REQ-007 i_operation  input  NB_OP  funct field delivered by ID/EX.
REQ-008 i_rs_data  input  NB_REG  forwarded rs operand (dividend / multiplicand / MTHI-MTLO source).
REQ-009 i_rt_data  input  NB_REG  forwarded rt operand (divisor / multiplier).
REQ-010 o_hi  output  NB_REG  HI register contents.
REQ-011 o_lo  output  NB_REG  LO register contents.
REQ-012 o_busy  output  1  high while an operation is in progress; the hazard unit stalls IF/ID/EX on it.
REQ-013 o_done  output  1  one-cycle pulse after HI/LO receive a mul/div result.

Function
REQ-014 Supported funct codes: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13; any other code with i_start is ignored.
REQ-015 FSM states: IDLE, CALC, FINISH; o_busy = (state != IDLE), combinational from the state.
REQ-016 IDLE, i_start=1, i_dunit_clk_en=1, mul/div funct: latch operand magnitudes, operation type and sign flags; clear the 6-bit iteration counter; go to CALC.
REQ-017 CALC: one radix-2 iteration per enabled edge (shift-add multiply; restoring divide); go to FINISH after the 32nd iteration.
REQ-018 FINISH: on the next enabled edge, apply sign correction, write o_hi/o_lo, go to IDLE; o_done=1 for exactly the following cycle.
REQ-019 Latency: with the start edge counted as edge 0, HI/LO are written at edge 33 and o_busy is high for 33 cycles.
REQ-020 MULT/MULTU: {HI,LO} = the 64-bit product; signed product negated when the operand signs differ.
REQ-021 DIV/DIVU: LO = quotient, HI = remainder; signed quotient truncates toward zero; remainder takes the dividend's sign.
REQ-022 Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=i_rs_data unchanged; no sign correction; same 33-edge latency.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000 (wrap-around, no exception).
REQ-024 MTHI/MTLO in IDLE with i_start: write i_rs_data to HI/LO at that edge; o_busy and o_done stay low.
REQ-025 i_start while o_busy=1: ignored; the operation in flight continues unaffected.
REQ-026 i_dunit_clk_en=0: state, counter, datapath, o_hi, o_lo and o_done all hold their values; the operation resumes when the enable returns.
REQ-027 HI/LO change only at the FINISH edge (REQ-018) or on an MTHI/MTLO write (REQ-024); the intermediate partial product/remainder is never visible on o_hi/o_lo.

Reset
REQ-028 i_reset=1 at any edge, including mid-operation: state=IDLE, counter=0, o_hi=0, o_lo=0, o_done=0, o_busy=0; reset overrides i_dunit_clk_en.
REQ-029 An operation interrupted by reset is discarded; no partial write reaches HI/LO.

Verification
REQ-030 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> at edge 33 HI=0xFFFFFFFE, LO=0x00000001; o_done pulses once; o_busy high for 33 cycles.
REQ-031 MULT rs=0xFFFFFFFD (-3), rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; then DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 DIVU rs=0x12345678, rt=0 -> LO=0xFFFFFFFF, HI=0x12345678 at edge 33; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 DIVU 100/7 with i_dunit_clk_en low for 5 cycles mid-CALC -> result LO=14, HI=2 written at edge 38; a second i_start during CALC is ignored.
REQ-034 Start MULTU, assert i_reset at edge 10 -> o_busy=0, HI=LO=0 after that edge, no o_done pulse; MTLO rs=0xCAFEBABE in IDLE -> LO=0xCAFEBABE next edge, o_busy stays 0.
